// File: rtl/mips_prog_encoder_pkg.sv
// rtl/mips_prog_encoder_pkg.sv - mnemonic ids, opcodes, func codes and FSM states for the program encoder
package mips_prog_encoder_pkg;

    // Mnemonic ids carried on in_mnem; 20..31 are illegal
    localparam logic [4:0] MN_ADD  = 5'd0;
    localparam logic [4:0] MN_SUB  = 5'd1;
    localparam logic [4:0] MN_AND  = 5'd2;
    localparam logic [4:0] MN_OR   = 5'd3;
    localparam logic [4:0] MN_XOR  = 5'd4;
    localparam logic [4:0] MN_SLL  = 5'd5;
    localparam logic [4:0] MN_SRL  = 5'd6;
    localparam logic [4:0] MN_SRA  = 5'd7;
    localparam logic [4:0] MN_JR   = 5'd8;
    localparam logic [4:0] MN_ADDI = 5'd9;
    localparam logic [4:0] MN_ANDI = 5'd10;
    localparam logic [4:0] MN_ORI  = 5'd11;
    localparam logic [4:0] MN_XORI = 5'd12;
    localparam logic [4:0] MN_LW   = 5'd13;
    localparam logic [4:0] MN_SW   = 5'd14;
    localparam logic [4:0] MN_BEQ  = 5'd15;
    localparam logic [4:0] MN_BNE  = 5'd16;
    localparam logic [4:0] MN_LUI  = 5'd17;
    localparam logic [4:0] MN_J    = 5'd18;
    localparam logic [4:0] MN_JAL  = 5'd19;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_FULL = 2'd3
    } enc_state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sa,
                                           input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_instr_encode.sv
// rtl/mips_instr_encode.sv - combinational mnemonic plus fields to 32-bit MIPS word and legal flag
module mips_instr_encode
    import mips_prog_encoder_pkg::*;
(
    input  logic [4:0]  mnem_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  sa_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // Pack only the fields each format uses; forced-zero fields never see the inputs
    always_comb begin
        word_o  = 32'h0;
        legal_o = 1'b1;
        case (mnem_i)
            MN_ADD:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
            MN_SUB:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
            MN_AND:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_AND);
            MN_OR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_OR);
            MN_XOR:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
            MN_SLL:  word_o = r_word(5'd0, rt_i, rd_i, sa_i, FN_SLL);
            MN_SRL:  word_o = r_word(5'd0, rt_i, rd_i, sa_i, FN_SRL);
            MN_SRA:  word_o = r_word(5'd0, rt_i, rd_i, sa_i, FN_SRA);
            MN_JR:   word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_ADDI: word_o = i_word(OP_ADDI, rs_i, rt_i, imm_i);
            MN_ANDI: word_o = i_word(OP_ANDI, rs_i, rt_i, imm_i);
            MN_ORI:  word_o = i_word(OP_ORI,  rs_i, rt_i, imm_i);
            MN_XORI: word_o = i_word(OP_XORI, rs_i, rt_i, imm_i);
            MN_LW:   word_o = i_word(OP_LW,   rs_i, rt_i, imm_i);
            MN_SW:   word_o = i_word(OP_SW,   rs_i, rt_i, imm_i);
            MN_BEQ:  word_o = i_word(OP_BEQ,  rs_i, rt_i, imm_i);
            MN_BNE:  word_o = i_word(OP_BNE,  rs_i, rt_i, imm_i);
            MN_LUI:  word_o = i_word(OP_LUI,  5'd0, rt_i, imm_i);
            MN_J:    word_o = {OP_J, target_i};
            MN_JAL:  word_o = {OP_JAL, target_i};
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_prog_encoder.sv
// rtl/mips_prog_encoder.sv - streaming instruction encoder writing packed words to consecutive imem addresses
module mips_prog_encoder
    import mips_prog_encoder_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_sa,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err_illegal
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [31:0]       odata_q, odata_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept;

    mips_instr_encode u_encode (
        .mnem_i   (in_mnem),
        .rs_i     (in_rs),
        .rt_i     (in_rt),
        .rd_i     (in_rd),
        .sa_i     (in_sa),
        .imm_i    (in_imm),
        .target_i (in_target),
        .word_o   (enc_word),
        .legal_o  (enc_legal)
    );

    assign in_ready    = (state_q == ST_LOAD) && !start;
    assign accept      = in_valid && in_ready;
    assign out_we      = we_q;
    assign out_addr    = oaddr_q;
    assign out_data    = odata_q;
    assign count       = count_q;
    assign done        = done_q;
    assign full        = full_q;
    assign err_illegal = err_q;

    // State, address/count bookkeeping and write-port registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            oaddr_q <= BASE;
            odata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            done_q  <= done_d;
            full_q  <= full_d;
            err_q   <= err_d;
            we_q    <= we_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
        end
    end

    // Next state: start rewinds from anywhere; a beat is only taken while loading
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        done_d  = done_q;
        full_d  = full_q;
        err_d   = err_q;
        we_d    = 1'b0;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        if (start) begin
            state_d = ST_LOAD;
            addr_d  = BASE;
            count_d = '0;
            done_d  = 1'b0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (enc_legal) begin
                we_d    = 1'b1;
                oaddr_d = addr_q;
                odata_d = enc_word;
                count_d = count_q + 1'b1;
                // The top address parks the pointer; FULL or DONE follows immediately
                if (addr_q != LAST) begin
                    addr_d = addr_q + 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
            if (in_last) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else if (enc_legal && (addr_q == LAST)) begin
                state_d = ST_FULL;
                full_d  = 1'b1;
            end
        end
    end

endmodule
